// File: rtl/banco_pkg.sv
// Shared definitions for the parametrised register bank: sweep state encoding
// and the default sizing used when the bank is instantiated without overrides.
package banco_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } estado_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int NREAD_DEF  = 2;

endpackage

// File: rtl/banco_porta_leitura.sv
// One combinational read port of the register bank.
// Selects a register out of the flattened storage, optionally forwards the
// write data of the current cycle (BANCO_BYPASS_EN) and forces register 0 to
// read as zero when the hardwired-zero option is on.
module banco_porta_leitura
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic [(DATA_W << ADDR_W)-1:0] regs_flat,
    input  logic [ADDR_W-1:0]             rd_addr,
`ifdef BANCO_BYPASS_EN
    input  logic                          fwd_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
`endif
    output logic [DATA_W-1:0]             rd_data
);

    // Stored value, overridden by same-cycle write data, then zero-register mask
    always_comb begin
        rd_data = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
`ifdef BANCO_BYPASS_EN
        if (fwd_valid && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank with a multi-cycle bulk-clear sweep.
// Holds the storage array, the write port, the sweep counter and the
// IDLE/CLEAR state machine; NREAD read ports are built from banco_porta_leitura.
// Optional feature macro: BANCO_BYPASS_EN (same-cycle write-to-read forwarding).
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic [NREAD*ADDR_W-1:0] RegLido,
    output logic [NREAD*DATA_W-1:0] Dado,
    input  logic [ADDR_W-1:0]       RegEscr,
    input  logic [DATA_W-1:0]       DadoEscr,
    input  logic                    RegWrite,
    input  logic                    Clear,
    output logic                    Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   cont_q, cont_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                wr_ok;
    logic [DEPTH*DATA_W-1:0] regs_flat;

    // A write is taken only in IDLE, loses to Clear, and never touches a hardwired zero register
    assign wr_ok = (estado_q == IDLE) && RegWrite && !Clear &&
                   !((ZERO_REG != 0) && (RegEscr == '0));

    // Next state: start a sweep on Clear, otherwise write; during the sweep zero one register per edge
    always_comb begin
        mem_d    = mem_q;
        estado_d = estado_q;
        cont_d   = cont_q;
        busy_d   = busy_q;
        case (estado_q)
            IDLE: begin
                if (Clear) begin
                    estado_d = CLEAR;
                    cont_d   = '0;
                    busy_d   = 1'b1;
                end else if (wr_ok) begin
                    mem_d[RegEscr] = DadoEscr;
                end
            end
            CLEAR: begin
                mem_d[cont_q] = '0;
                cont_d        = cont_q + 1'b1;
                if (cont_q == ADDR_W'(DEPTH - 1)) begin
                    estado_d = IDLE;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                estado_d = IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State, counter, busy flag and storage registers; reset clears everything and abandons any sweep
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q <= IDLE;
            cont_q   <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            busy_q   <= busy_d;
            mem_q    <= mem_d;
        end
    end

    // Flatten the storage so every read port sees the whole bank on one vector
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    assign Busy = busy_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_porta
        banco_porta_leitura #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_porta (
            .regs_flat (regs_flat),
            .rd_addr   (RegLido[k*ADDR_W +: ADDR_W]),
`ifdef BANCO_BYPASS_EN
            .fwd_valid (wr_ok),
            .wr_addr   (RegEscr),
            .wr_data   (DadoEscr),
`endif
            .rd_data   (Dado[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Self-checking bench for banco_registradores_param: a default bank, a
// hardwired-zero bank and a wide 4-port bank share clock and reset.
module tb_banco_registradores_param;

    logic clk;
    logic rst_n;

    // default bank: 8-bit, 8 registers, 2 read ports
    logic [5:0]  a_lido;
    logic [15:0] a_dado;
    logic [2:0]  a_escr;
    logic [7:0]  a_dado_escr;
    logic        a_we, a_clear, a_busy;

    // hardwired-zero bank
    logic [5:0]  z_lido;
    logic [15:0] z_dado;
    logic [2:0]  z_escr;
    logic [7:0]  z_dado_escr;
    logic        z_we, z_clear, z_busy;

    // wide bank: 16-bit, 16 registers, 4 read ports
    logic [15:0] b_lido;
    logic [63:0] b_dado;
    logic [3:0]  b_escr;
    logic [15:0] b_dado_escr;
    logic        b_we, b_clear, b_busy;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr0;
        logic [2:0] raddr1;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vec [13];

    banco_registradores_param u_dut_a (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .RegLido  (a_lido),
        .Dado     (a_dado),
        .RegEscr  (a_escr),
        .DadoEscr (a_dado_escr),
        .RegWrite (a_we),
        .Clear    (a_clear),
        .Busy     (a_busy)
    );

    banco_registradores_param #(.ZERO_REG(1)) u_dut_z (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .RegLido  (z_lido),
        .Dado     (z_dado),
        .RegEscr  (z_escr),
        .DadoEscr (z_dado_escr),
        .RegWrite (z_we),
        .Clear    (z_clear),
        .Busy     (z_busy)
    );

    banco_registradores_param #(.DATA_W(16), .ADDR_W(4), .NREAD(4)) u_dut_b (
        .Clock    (clk),
        .Reset_n  (rst_n),
        .RegLido  (b_lido),
        .Dado     (b_dado),
        .RegEscr  (b_escr),
        .DadoEscr (b_dado_escr),
        .RegWrite (b_we),
        .Clear    (b_clear),
        .Busy     (b_busy)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one cycle of inputs on the default bank at a falling edge, settle before checking
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic clr, input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk);
        a_we        = we;
        a_escr      = wa;
        a_dado_escr = wd;
        a_clear     = clr;
        a_lido      = {r1, r0};
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] exp_byp;
        int         cnt;

        n_compared   = 0;
        n_mismatched = 0;

        vec[0]  = '{1'b1, 3'd0, 8'h01, 3'd1, 3'd7, 8'h00, 8'h00};
        vec[1]  = '{1'b1, 3'd1, 8'h02, 3'd2, 3'd0, 8'h00, 8'h01};
        vec[2]  = '{1'b1, 3'd2, 8'h03, 3'd3, 3'd1, 8'h00, 8'h02};
        vec[3]  = '{1'b1, 3'd3, 8'h04, 3'd4, 3'd2, 8'h00, 8'h03};
        vec[4]  = '{1'b1, 3'd4, 8'h05, 3'd5, 3'd3, 8'h00, 8'h04};
        vec[5]  = '{1'b1, 3'd5, 8'h06, 3'd6, 3'd4, 8'h00, 8'h05};
        vec[6]  = '{1'b1, 3'd6, 8'h07, 3'd7, 3'd5, 8'h00, 8'h06};
        vec[7]  = '{1'b1, 3'd7, 8'h08, 3'd0, 3'd6, 8'h01, 8'h07};
        vec[8]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h01, 8'h08};
        vec[9]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 8'h04, 8'h05};
        vec[10] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h03, 8'h03};
        vec[11] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 8'h07, 8'h02};
        vec[12] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd7, 8'h06, 8'h08};

        a_we = 0; a_escr = 0; a_dado_escr = 0; a_clear = 0; a_lido = 0;
        z_we = 0; z_escr = 0; z_dado_escr = 0; z_clear = 0; z_lido = 0;
        b_we = 0; b_escr = 0; b_dado_escr = 0; b_clear = 0; b_lido = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        a_lido = {3'd7, 3'd3};
        #1;
        checkOutput("reset_a_port0", 32'(a_dado[7:0]), 32'h00);
        checkOutput("reset_a_port1", 32'(a_dado[15:8]), 32'h00);
        checkOutput("reset_a_busy", 32'(a_busy), 32'h0);
        checkOutput("reset_z_busy", 32'(z_busy), 32'h0);
        checkOutput("reset_b_busy", 32'(b_busy), 32'h0);

        // table: write i+1 into register i, then read back pairs
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vec[i].we, vec[i].waddr, vec[i].wdata, 1'b0, vec[i].raddr0, vec[i].raddr1);
            checkOutput($sformatf("vec%0d_port0", i), 32'(a_dado[7:0]), 32'(vec[i].exp0));
            checkOutput($sformatf("vec%0d_port1", i), 32'(a_dado[15:8]), 32'(vec[i].exp1));
            checkOutput($sformatf("vec%0d_busy", i), 32'(a_busy), 32'h0);
        end

        // same-cycle read of the address being written
`ifdef BANCO_BYPASS_EN
        exp_byp = 8'h3C;
`else
        exp_byp = 8'h06;
`endif
        applyStimulus(1'b1, 3'd5, 8'h3C, 1'b0, 3'd5, 3'd4);
        checkOutput("bypass_same_cycle", 32'(a_dado[7:0]), 32'(exp_byp));
        checkOutput("bypass_other_port", 32'(a_dado[15:8]), 32'h05);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd0);
        checkOutput("bypass_next_cycle", 32'(a_dado[7:0]), 32'h3C);
        checkOutput("bypass_reg0", 32'(a_dado[15:8]), 32'h01);

        // fill with FF and launch a sweep
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 8'hFF, 1'b0, 3'd0, 3'd0);
        end
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7);
        checkOutput("clear_pre_busy", 32'(a_busy), 32'h0);
        checkOutput("clear_pre_reg0", 32'(a_dado[7:0]), 32'hFF);
        checkOutput("clear_pre_reg7", 32'(a_dado[15:8]), 32'hFF);

        // after k sweep edges registers 0..k-1 are zero; write at k=1 and Clear at k=3 are ignored
        for (int k = 0; k <= 8; k++) begin
            applyStimulus((k == 1), 3'd6, 8'h11, (k == 3),
                          (k == 0) ? 3'd0 : 3'(k - 1), (k < 8) ? 3'(k) : 3'd7);
            checkOutput($sformatf("sweep%0d_busy", k), 32'(a_busy), (k < 8) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sweep%0d_low", k), 32'(a_dado[7:0]), (k == 0) ? 32'hFF : 32'h00);
            checkOutput($sformatf("sweep%0d_high", k), 32'(a_dado[15:8]), (k < 8) ? 32'hFF : 32'h00);
        end

        // first write after the sweep lands
        applyStimulus(1'b1, 3'd2, 8'h5A, 1'b0, 3'd3, 3'd7);
        checkOutput("post_sweep_busy", 32'(a_busy), 32'h0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd1);
        checkOutput("post_sweep_write", 32'(a_dado[7:0]), 32'h5A);
        checkOutput("post_sweep_reg1", 32'(a_dado[15:8]), 32'h00);
        checkOutput("post_sweep_no_retrigger", 32'(a_busy), 32'h0);

        // reset in the middle of a sweep
        applyStimulus(1'b1, 3'd7, 8'h77, 1'b0, 3'd5, 3'd7);
        applyStimulus(1'b1, 3'd5, 8'h55, 1'b0, 3'd5, 3'd7);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd7);
        checkOutput("midrst_pre_reg5", 32'(a_dado[7:0]), 32'h55);
        checkOutput("midrst_pre_reg7", 32'(a_dado[15:8]), 32'h77);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd7);
        end
        checkOutput("midrst_sweep_busy", 32'(a_busy), 32'h1);
        checkOutput("midrst_sweep_reg5", 32'(a_dado[7:0]), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(a_busy), 32'h0);
        checkOutput("midrst_reg5", 32'(a_dado[7:0]), 32'h00);
        checkOutput("midrst_reg7", 32'(a_dado[15:8]), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd4, 8'h44, 1'b0, 3'd6, 3'd5);
        checkOutput("afterrst_reg6", 32'(a_dado[7:0]), 32'h00);
        checkOutput("afterrst_busy", 32'(a_busy), 32'h0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd3);
        checkOutput("afterrst_write", 32'(a_dado[7:0]), 32'h44);
        checkOutput("afterrst_reg3", 32'(a_dado[15:8]), 32'h00);
        checkOutput("afterrst_no_resume", 32'(a_busy), 32'h0);

        // hardwired zero register
        @(negedge clk);
        z_we = 1'b1; z_escr = 3'd0; z_dado_escr = 8'hAA; z_lido = {3'd3, 3'd0};
        #1;
        checkOutput("zero_same_cycle", 32'(z_dado[7:0]), 32'h00);
        @(negedge clk);
        z_escr = 3'd3; z_dado_escr = 8'h55;
        #1;
`ifdef BANCO_BYPASS_EN
        exp_byp = 8'h55;
`else
        exp_byp = 8'h00;
`endif
        checkOutput("zero_reg0_dropped", 32'(z_dado[7:0]), 32'h00);
        checkOutput("zero_reg3_same_cycle", 32'(z_dado[15:8]), 32'(exp_byp));
        @(negedge clk);
        z_we = 1'b0;
        #1;
        checkOutput("zero_reg0_after", 32'(z_dado[7:0]), 32'h00);
        checkOutput("zero_reg3_after", 32'(z_dado[15:8]), 32'h55);

        // wide 4-port bank
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_we = 1'b1; b_escr = 4'(i); b_dado_escr = 16'hA000 | 16'(i);
        end
        @(negedge clk);
        b_we = 1'b0;
        b_lido = {4'd9, 4'd0, 4'd15, 4'd3};
        #1;
        checkOutput("wide_port0", 32'(b_dado[15:0]), 32'hA003);
        checkOutput("wide_port1", 32'(b_dado[31:16]), 32'hA00F);
        checkOutput("wide_port2", 32'(b_dado[47:32]), 32'hA000);
        checkOutput("wide_port3", 32'(b_dado[63:48]), 32'hA009);
        b_clear = 1'b1;
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            b_clear = 1'b0;
            if (b_busy) cnt++;
            else if (cnt > 0) break;
        end
        #1;
        checkOutput("wide_busy_cycles", 32'(cnt), 32'd16);
        checkOutput("wide_cleared_port0", 32'(b_dado[15:0]), 32'h0000);
        checkOutput("wide_cleared_port1", 32'(b_dado[31:16]), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/banco_registradores_param.md
# banco_registradores_param

Parametrised register file, the next-generation register bank of the 8-bit processor datapath. It has configurable data width, depth and number of read ports, and an optional hardwired-zero register 0. It adds a multi-cycle bulk-clear sequencer with a busy flag and optional same-cycle write-to-read forwarding. It sits between instruction decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, 8: width of each register in bits.
- ADDR_W, 3: register address width; DEPTH = 2**ADDR_W.
- NREAD, 2: number of independent read ports, ≥1.
- ZERO_REG, 0: when 1, register 0 reads as zero and ignores writes.

Ports (one clock; reset is asynchronous and active-low):
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- RegLido  in  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- Dado  out  NREAD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- RegEscr  in  ADDR_W  write address.
- DadoEscr  in  DATA_W  write data.
- RegWrite  in  1  write enable.
- Clear  in  1  bulk-clear request, sampled on a rising edge.
- Busy  out  1  high while a clear sweep is in progress.

## Operation
- Reset (Reset_n=0, asynchronous):
  - all registers 0; state IDLE; sweep counter 0; Busy 0.
  - Dado therefore reads 0 on every port.
- States: IDLE, CLEAR.
- IDLE, write:
  - if RegWrite=1 and Clear=0, the register at RegEscr takes DadoEscr on the edge.
  - if ZERO_REG=1 and RegEscr=0, the write is dropped.
- IDLE, Clear=1 at an edge:
  - go to CLEAR, counter←0, Busy←1.
  - a RegWrite in the same cycle is ignored; Clear has priority.
- CLEAR:
  - each edge zeroes the register at counter, then counter increments.
  - the edge that zeroes register DEPTH-1 returns to IDLE with Busy←0; the counter wraps to 0.
  - RegWrite is ignored throughout CLEAR.
  - Clear asserted during CLEAR is ignored; it does not restart the sweep.
- Reads:
  - combinational, Dado[k] = register[RegLido[k]].
  - all ports are independent and may address the same register.
  - during CLEAR, reads return current contents: already-zeroed registers read 0, the rest hold their old values.
  - ZERO_REG=1 and address 0 → 0 always.
- Reset_n low mid-sweep: immediate return to IDLE with all registers 0. No sweep resumes after reset.

## Timing
- Write latency: one edge. Data is visible on reads in the cycle after the write edge, or in the same cycle when forwarding is enabled.
- Read latency: zero cycles (combinational).
- Clear:
  - Busy rises on the edge that samples Clear.
  - Busy stays high for exactly DEPTH cycles.
  - the first write accepted after a clear is on the edge where Busy falls + 1 cycle, i.e. the first edge with Busy=0 at its start.
- Minimum Clear pulse: one cycle. A level held high re-triggers on the first IDLE edge after the sweep ends.

## Configuration
- BANCO_BYPASS_EN defined: write-to-read forwarding.
  - condition: RegWrite=1, state IDLE, Clear=0, RegEscr==RegLido[k], and not (ZERO_REG=1 and address 0).
  - when the condition holds, Dado[k] = DadoEscr combinationally in the same cycle.
- BANCO_BYPASS_EN undefined: Dado[k] always reflects stored contents only. A same-cycle read of the written address returns the old value.

## Structure
- Package banco_pkg holds:
  - the state typedef (IDLE, CLEAR);
  - default-parameter constants for DATA_W, ADDR_W and NREAD.
- Sub-module banco_porta_leitura: one read port, covering address decode, zero-register masking and the optional bypass mux. It is instantiated NREAD times in a generate loop.
- The top level holds the storage array, the write logic, the sweep counter and the FSM.

## Test plan
- Reset with defaults, then write register i with value i+1 for i=0..7, then read all 8 addresses on both ports → Dado returns 1..8; reading before any write after reset → 0.
- ZERO_REG=1: write 8'hAA to register 0 → Dado reads 0; write 8'h55 to register 3 → reads 8'h55.
- Fill all registers with 8'hFF, pulse Clear one cycle → Busy high exactly 8 cycles; after k edges in CLEAR, registers 0..k-1 read 0 and the rest 8'hFF; a RegWrite during the sweep has no effect; Clear re-asserted mid-sweep does not extend Busy.
- Pull Reset_n low at sweep cycle 3 → Busy 0 and all registers 0 immediately; the next write lands normally.
- BANCO_BYPASS_EN defined, RegWrite=1, RegEscr=5, DadoEscr=8'h3C, RegLido port0=5 → Dado port0=8'h3C in the same cycle. Undefined → old value until the next cycle.
- NREAD=4, DATA_W=16, ADDR_W=4: four distinct simultaneous reads after 16 writes → each port returns its own register; Clear → Busy high 16 cycles.
